// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache for the MEM
//   stage of a 5-stage pipeline. It has 8 lines of 4 words (128 B).
//   A read hit returns data in the same cycle with no stall. A read miss
//   stalls the pipeline and refills the whole line one word at a time.
//   Every store goes out to main memory. A store that hits also updates
//   the cached word.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   addr                  byte address from EX/MEM (addr[1:0] ignored)
//   mem_read, mem_write   load / store request from EX/MEM
//   write_data            store data
//   read_data             load data, valid when mem_read=1 and stall=0
//   stall                 freeze upstream stages, bubble into MEM/WB
//   mem_addr              word-aligned main-memory address
//   mem_rd, mem_wr        main-memory strobes, held until mem_ready
//   mem_wdata             main-memory write data
//   mem_rdata, mem_ready  main-memory read data / one-cycle completion pulse
//   hit_count, miss_count saturating access statistics
module data_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  valid;
  logic [24:0] tags [8];
  logic [31:0] data [32];
  logic [1:0]  cnt;
  logic        refill_return;

  logic [1:0]  offset;
  logic [2:0]  index;
  logic [24:0] tag;
  logic        hit;
  logic        unused_addr_bits;

  assign offset           = addr[3:2];
  assign index            = addr[6:4];
  assign tag              = addr[31:7];
  assign hit              = valid[index] && (tags[index] == tag);
  assign unused_addr_bits = ^addr[1:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next state and outputs. A store always goes through WRITE, even when
  // mem_read is also asserted. WDONE lets the store retire for exactly one
  // cycle before the cache accepts the next request.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    read_data  = data[{index, offset}];
    case (state)
      IDLE: begin
        if (mem_write) begin
          stall      = 1'b1;
          state_next = WRITE;
        end else if (mem_read && !hit) begin
          stall      = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {tag, index, cnt, 2'b00};
        if (mem_ready && (cnt == 2'd3)) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = write_data;
        if (mem_ready) begin
          state_next = WDONE;
        end
      end
      WDONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, line metadata and statistics.
  // The line is invalidated when a refill starts. A refill that is aborted
  // by reset, or that overwrites an evicted line, therefore never exposes
  // a partial line.
  // refill_return marks the IDLE cycle right after a refill. In that cycle
  // the held load now hits, but it was already counted as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      cnt           <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      refill_return <= 1'b0;
    end else begin
      state         <= state_next;
      refill_return <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            if (hit) begin
              if (mem_write || !refill_return) begin
                hit_count <= sat_inc(hit_count);
              end
            end else begin
              miss_count <= sat_inc(miss_count);
            end
          end
          if (mem_read && !mem_write && !hit) begin
            cnt          <= '0;
            valid[index] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[index]  <= 1'b1;
              tags[index]   <= tag;
              refill_return <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Data array. It has no reset; contents only matter behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state == REFILL) && mem_ready) begin
        data[{index, cnt}] <= mem_rdata;
      end else if ((state == IDLE) && mem_write && hit) begin
        data[{index, offset}] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Directed bench for data_cache. A small main-memory model answers each
//   strobe with a one-cycle mem_ready pulse on the second cycle of that
//   strobe. Expected values are computed by hand for each access.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int          total_checks = 0;
  int          bad_checks   = 0;
  int          wait_cnt;
  int          stall_cycles;
  logic [31:0] first_maddr;
  logic [31:0] last_maddr;
  logic [31:0] last_wdata;
  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  function automatic logic [31:0] readModel(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic rd,
                               input logic wr, input logic [31:0] wd);
    @(negedge clk);
    addr       = a;
    mem_read   = rd;
    mem_write  = wr;
    write_data = wd;
    #1;
  endtask

  // Issue one request and hold it while stall is high. Returns at the
  // first cycle with stall low, where read_data is valid.
  task automatic runAccess(input logic [31:0] a, input logic rd,
                           input logic wr, input logic [31:0] wd);
    bit seen;
    seen         = 1'b0;
    applyStimulus(a, rd, wr, wd);
    stall_cycles = 0;
    first_maddr  = '0;
    last_maddr   = '0;
    last_wdata   = '0;
    while (stall && stall_cycles < 60) begin
      stall_cycles++;
      if (mem_rd || mem_wr) begin
        if (!seen) first_maddr = mem_addr;
        seen       = 1'b1;
        last_maddr = mem_addr;
        last_wdata = mem_wdata;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("stall_released", {31'd0, stall}, 32'd0);
  endtask

  task automatic idleCycle();
    applyStimulus(32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Main-memory model: acts just after each rising edge, so mem_ready and
  // mem_rdata are stable well before the next edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = (mem_rd || mem_wr) ? 1 : 0;
      end else if (mem_rd || mem_wr) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = readModel(mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    mem_model[32'h40] = 32'hA0;
    mem_model[32'h44] = 32'hA1;
    mem_model[32'h48] = 32'hA2;
    mem_model[32'h4C] = 32'hA3;
    rst        = 1'b1;
    addr       = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_hits", {16'd0, hit_count}, 32'd0);
    checkOutput("rst_misses", {16'd0, miss_count}, 32'd0);

    // Cold read miss followed by a full line refill.
    runAccess(32'h40, 1'b1, 1'b0, 32'd0);
    checkOutput("cold_stall_cycles", stall_cycles, 32'd9);
    checkOutput("cold_first_addr", first_maddr, 32'h40);
    checkOutput("cold_last_addr", last_maddr, 32'h4C);
    checkOutput("cold_data", read_data, 32'hA0);
    checkOutput("cold_misses", {16'd0, miss_count}, 32'd1);

    // Hit in the same line. The refill-return cycle before it is not counted.
    runAccess(32'h4C, 1'b1, 1'b0, 32'd0);
    checkOutput("hit_stall_cycles", stall_cycles, 32'd0);
    checkOutput("hit_data", read_data, 32'hA3);
    checkOutput("hit_suppressed", {16'd0, hit_count}, 32'd0);
    idleCycle();
    checkOutput("hit_count_1", {16'd0, hit_count}, 32'd1);

    // Write hit: the store goes through, then a one-cycle WDONE.
    runAccess(32'h44, 1'b0, 1'b1, 32'h12345678);
    checkOutput("whit_stall_cycles", stall_cycles, 32'd3);
    checkOutput("whit_mem_addr", first_maddr, 32'h44);
    checkOutput("whit_mem_wdata", last_wdata, 32'h12345678);
    checkOutput("wdone_no_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
    idleCycle();
    checkOutput("whit_hits", {16'd0, hit_count}, 32'd2);
    runAccess(32'h44, 1'b1, 1'b0, 32'd0);
    checkOutput("whit_read_stall", stall_cycles, 32'd0);
    checkOutput("whit_read_data", read_data, 32'h12345678);
    idleCycle();
    checkOutput("whit_read_hits", {16'd0, hit_count}, 32'd3);

    // Write miss: no allocation, so the next read of the address misses.
    runAccess(32'h400, 1'b0, 1'b1, 32'hCAFEF00D);
    checkOutput("wmiss_stall_cycles", stall_cycles, 32'd3);
    checkOutput("wmiss_mem_addr", first_maddr, 32'h400);
    idleCycle();
    checkOutput("wmiss_misses", {16'd0, miss_count}, 32'd2);
    runAccess(32'h400, 1'b1, 1'b0, 32'd0);
    checkOutput("wmiss_read_stall", stall_cycles, 32'd9);
    checkOutput("wmiss_read_addr", first_maddr, 32'h400);
    checkOutput("wmiss_read_data", read_data, 32'hCAFEF00D);
    checkOutput("wmiss_read_misses", {16'd0, miss_count}, 32'd3);

    // Conflict on index 4: 0xC0 evicts the 0x40 line.
    runAccess(32'h40, 1'b1, 1'b0, 32'd0);
    checkOutput("conf_pre_hit_stall", stall_cycles, 32'd0);
    checkOutput("conf_pre_hit_data", read_data, 32'hA0);
    runAccess(32'hC0, 1'b1, 1'b0, 32'd0);
    checkOutput("conf_evict_stall", stall_cycles, 32'd9);
    checkOutput("conf_evict_data", read_data, 32'hDEAD00C0);
    runAccess(32'h40, 1'b1, 1'b0, 32'd0);
    checkOutput("conf_reread_stall", stall_cycles, 32'd9);
    checkOutput("conf_reread_data", read_data, 32'hA0);
    runAccess(32'h44, 1'b1, 1'b0, 32'd0);
    checkOutput("conf_wt_data", read_data, 32'h12345678);
    idleCycle();
    checkOutput("conf_misses", {16'd0, miss_count}, 32'd5);
    checkOutput("conf_hits", {16'd0, hit_count}, 32'd5);

    // Reset in the middle of a refill, after the second word returns.
    applyStimulus(32'h80, 1'b1, 1'b0, 32'd0);
    n   = 0;
    cyc = 0;
    while (n < 2 && cyc < 60) begin
      if (mem_ready) n++;
      cyc++;
      @(negedge clk);
      #1;
    end
    checkOutput("abort_ready_seen", n, 32'd2);
    checkOutput("abort_pre_rd", {31'd0, mem_rd}, 32'd1);
    checkOutput("abort_pre_addr", mem_addr, 32'h88);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_rd_dropped", {31'd0, mem_rd}, 32'd0);
    checkOutput("abort_stall", {31'd0, stall}, 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    checkOutput("abort_hits", {16'd0, hit_count}, 32'd0);
    checkOutput("abort_misses", {16'd0, miss_count}, 32'd0);
    runAccess(32'h80, 1'b1, 1'b0, 32'd0);
    checkOutput("abort_reread_stall", stall_cycles, 32'd9);
    checkOutput("abort_reread_data", read_data, 32'hDEAD0080);
    checkOutput("abort_reread_misses", {16'd0, miss_count}, 32'd1);
    runAccess(32'h40, 1'b1, 1'b0, 32'd0);
    checkOutput("post_rst_40_stall", stall_cycles, 32'd9);
    checkOutput("post_rst_40_data", read_data, 32'hA0);
    idleCycle();
    checkOutput("post_rst_misses", {16'd0, miss_count}, 32'd2);
    checkOutput("post_rst_hits", {16'd0, hit_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
